decode_stage: RTL

- Consumes the IF/ID register (pc, instruction) produced by the fetch stage.
- Reads the integer register file and decodes RV32I control fields and immediates.
- Registers the result into the ID/EX pipeline register that feeds execute.
- Owns the register file write port for writeback, detects load-use hazards, and inserts bubbles on stall or flush.

---
 rtl/decode_stage_pkg.sv | 56 +++++
 rtl/decode_stage_register_file.sv | 33 +++
 rtl/decode_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared ID/EX payload type, RV32I opcodes and ALU op encoding
package decode_stage_pkg;

    localparam int PC_WIDTH = 32;
    localparam int XLEN     = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND} alu_op_type;

    typedef struct packed {
        logic                valid;
        logic [PC_WIDTH-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        alu_op_type          alu_op;
        logic                alu_src_imm;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                branch;
        logic                jump;
        logic                jalr;
        logic                lui;
        logic                auipc;
        logic [2:0]          funct3;
        logic                illegal;
    } id_ex_type;

    // alt selects SUB/SRA; callers pass it only where funct7[5] is meaningful
    function automatic alu_op_type alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? SUB : ADD;
            3'd1:    return SLL;
            3'd2:    return SLT;
            3'd3:    return SLTU;
            3'd4:    return XOR;
            3'd5:    return alt ? SRA : SRL;
            3'd6:    return OR;
            default: return AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// register_file: 32 x XLEN integer registers, two async reads with write-through bypass
module register_file
    import decode_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            we_i,
    input  logic [4:0]      wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i
);

    logic [XLEN-1:0] regs_q [32];

    // clear on reset; x0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) regs_q[k] <= '0;
        end else if (we_i && wr_addr_i != 5'd0) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // x0 reads zero; a same-cycle write to the read address is forwarded
    always_comb begin
        rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : (we_i && wr_addr_i == rs1_addr_i) ? wr_data_i : regs_q[rs1_addr_i];
        rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : (we_i && wr_addr_i == rs2_addr_i) ? wr_data_i : regs_q[rs2_addr_i];
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode, register read, load-use stall and ID/EX register
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                if_id_valid,
    input  logic [PC_WIDTH-1:0] if_id_pc,
    input  logic [31:0]         if_id_instruction,
    input  logic                flush,
    input  logic                wb_write_enable,
    input  logic [4:0]          wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    output logic                hazard_stall,
    output id_ex_type           id_ex
);

    logic [31:0]     ins;
    logic [6:0]      opc;
    logic            is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_op_imm, is_op;
    logic            legal, rs1_used, rs2_used, reg_write;
    logic [XLEN-1:0] rf_rs1, rf_rs2, imm;
    id_ex_type       dec, id_ex_d, id_ex_q;

    assign ins       = if_id_instruction;
    assign opc       = ins[6:0];
    assign is_lui    = opc == OPC_LUI;
    assign is_auipc  = opc == OPC_AUIPC;
    assign is_jal    = opc == OPC_JAL;
    assign is_jalr   = opc == OPC_JALR;
    assign is_branch = opc == OPC_BRANCH;
    assign is_load   = opc == OPC_LOAD;
    assign is_store  = opc == OPC_STORE;
    assign is_op_imm = opc == OPC_OP_IMM;
    assign is_op     = opc == OPC_OP;
    assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store | is_op_imm | is_op;
    assign rs1_used  = ~(is_lui | is_auipc | is_jal);
    assign rs2_used  = is_op | is_branch | is_store;
    assign reg_write = is_lui | is_auipc | is_jal | is_jalr | is_load | is_op_imm | is_op;

    register_file u_register_file (
        .clk       (clk),
        .reset     (reset),
        .rs1_addr_i(ins[19:15]),
        .rs2_addr_i(ins[24:20]),
        .rs1_data_o(rf_rs1),
        .rs2_data_o(rf_rs2),
        .we_i      (wb_write_enable),
        .wr_addr_i (wb_rd),
        .wr_data_i (wb_data)
    );

    // sign-extended immediate selected by instruction format; R-type and illegal give 0
    always_comb begin
        imm = (is_lui | is_auipc)              ? XLEN'($signed({ins[31:12], 12'b0})) :
              is_jal                           ? XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})) :
              is_branch                        ? XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})) :
              is_store                         ? XLEN'($signed({ins[31:25], ins[11:7]})) :
              (is_load | is_op_imm | is_jalr)  ? XLEN'($signed(ins[31:20])) : '0;
    end

    // control decode; an empty IF/ID slot decodes to an all-zero payload
    always_comb begin
        dec = '0;
        if (if_id_valid) begin
            dec.valid       = 1'b1;
            dec.pc          = if_id_pc;
            dec.rs1         = rs1_used ? ins[19:15] : 5'd0;
            dec.rs2         = rs2_used ? ins[24:20] : 5'd0;
            dec.rd          = reg_write ? ins[11:7] : 5'd0;
            dec.rs1_data    = rs1_used ? rf_rs1 : '0;
            dec.rs2_data    = rs2_used ? rf_rs2 : '0;
            dec.imm         = imm;
            dec.alu_op      = is_op ? alu_decode(ins[14:12], ins[30]) :
                              is_op_imm ? alu_decode(ins[14:12], ins[14:12] == 3'd5 && ins[30]) :
                              is_branch ? SUB : ADD;
            dec.alu_src_imm = legal & ~is_op & ~is_branch;
            dec.mem_read    = is_load;
            dec.mem_write   = is_store;
            dec.reg_write   = reg_write;
            dec.branch      = is_branch;
            dec.jump        = is_jal | is_jalr;
            dec.jalr        = is_jalr;
            dec.lui         = is_lui;
            dec.auipc       = is_auipc;
            dec.funct3      = ins[14:12];
            dec.illegal     = ~legal;
        end
    end

    // load-use: the load in ID/EX writes a register this instruction reads; a flush overrides
    always_comb begin
        hazard_stall = ~reset & if_id_valid & id_ex_q.valid & id_ex_q.mem_read & (id_ex_q.rd != 5'd0) &
                       ((rs1_used & ins[19:15] == id_ex_q.rd) | (rs2_used & ins[24:20] == id_ex_q.rd)) & ~flush;
        id_ex_d      = (flush | hazard_stall) ? '0 : dec;
    end

    // ID/EX register; flush and stall both load a zero bubble
    always_ff @(posedge clk) begin
        id_ex_q <= reset ? '0 : id_ex_d;
    end

    assign id_ex = id_ex_q;

endmodule
